// File: rtl/bus_master_if.sv
// Single-outstanding bus master: takes one pipeline request, drives it onto the
// shared bus until the slave mux answers or the wait budget runs out, then pulses a response.
module bus_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_rdy,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last wait cycle value of the counter; reaching it without bus_rdy is a timeout.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            bus_we    <= req_we;
            bus_addr  <= req_addr;
            bus_wdata <= req_we ? req_wdata : '0;
            tmo_cnt   <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A ready in the final wait cycle still counts as success.
          if (bus_rdy) begin
            resp_rdata <= bus_we ? '0 : bus_rdata;
            resp_err   <= 1'b0;
            state      <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          bus_we    <= 1'b0;
          bus_addr  <= '0;
          bus_wdata <= '0;
          state     <= IDLE;
        end
        default: begin
          bus_we    <= 1'b0;
          bus_addr  <= '0;
          bus_wdata <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign bus_req    = (state == BUSY);
  assign resp_valid = (state == DONE);
  assign stall      = (state != IDLE);

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: read, write with waits, timeout and its edge,
// asynchronous reset mid-access, and back-to-back throughput.
module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rdy;
  logic [31:0] bus_rdata;

  int n_vec = 0;
  int n_err = 0;

  bus_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdy(bus_rdy), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    int cnt;
    int cyc;
    int n_resp;
    logic [8:0] ready_seq;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    bus_rdy = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    #5 rst_n = 1'b1;
    tick();

    // Read, zero wait
    issue(1'b0, 32'h0000_1000, 32'h5555_5555);
    chk("rd_ready_c0", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("rd_bus_req_c1", bus_req, 1);
    chk("rd_bus_addr_c1", bus_addr, 32'h0000_1000);
    chk("rd_bus_we_c1", bus_we, 0);
    chk("rd_bus_wdata_c1", bus_wdata, 0);
    chk("rd_stall_c1", stall, 1);
    bus_rdy = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_rdy = 1'b0; bus_rdata = 32'h1111_1111;
    chk("rd_resp_valid_c2", resp_valid, 1);
    chk("rd_resp_rdata_c2", resp_rdata, 32'hDEAD_BEEF);
    chk("rd_resp_err_c2", resp_err, 0);
    chk("rd_bus_req_c2", bus_req, 0);
    tick();
    chk("rd_resp_valid_c3", resp_valid, 0);
    chk("rd_ready_c3", req_ready, 1);
    chk("rd_bus_addr_idle", bus_addr, 0);
    chk("rd_rdata_hold", resp_rdata, 32'hDEAD_BEEF);

    // Write, three wait cycles; requests during BUSY are ignored
    issue(1'b1, 32'h0000_2000, 32'h1234_5678);
    tick();
    issue(1'b1, 32'h0000_3000, 32'h9999_9999);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("wr_bus_wdata_c%0d", c), bus_wdata, 32'h1234_5678);
      chk($sformatf("wr_bus_addr_c%0d", c), bus_addr, 32'h0000_2000);
      chk($sformatf("wr_resp_valid_c%0d", c), resp_valid, 0);
      if (c == 4) begin
        bus_rdy = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        req_valid = 1'b0;
      end
      tick();
    end
    bus_rdy = 1'b0;
    chk("wr_resp_valid_c5", resp_valid, 1);
    chk("wr_resp_rdata_c5", resp_rdata, 0);
    chk("wr_resp_err_c5", resp_err, 0);
    tick();

    // Timeout: bus never ready
    issue(1'b0, 32'h0000_4000, 32'h0);
    tick();
    req_valid = 1'b0;
    cnt = 0; cyc = 1;
    while (!resp_valid && cyc < 40) begin
      if (bus_req) cnt++;
      tick();
      cyc++;
    end
    chk("to_bus_req_cycles", cnt, 16);
    chk("to_resp_cycle", cyc, 17);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_rdata", resp_rdata, 0);
    tick();
    chk("to_err_hold", resp_err, 1);

    // Ready arrives in the last wait cycle: success wins
    issue(1'b0, 32'h0000_5000, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 16; c++) tick();
    chk("to_edge_bus_req_c16", bus_req, 1);
    bus_rdy = 1'b1; bus_rdata = 32'hA5A5_A5A5;
    tick();
    bus_rdy = 1'b0;
    chk("to_edge_resp_valid", resp_valid, 1);
    chk("to_edge_resp_err", resp_err, 0);
    chk("to_edge_resp_rdata", resp_rdata, 32'hA5A5_A5A5);
    tick();

    // Asynchronous reset during BUSY cycle 2
    issue(1'b1, 32'h0000_6000, 32'hCAFE_F00D);
    tick();
    req_valid = 1'b0;
    tick();
    chk("ar_bus_req_pre", bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_bus_req", bus_req, 0);
    chk("ar_stall", stall, 0);
    chk("ar_bus_addr", bus_addr, 0);
    chk("ar_bus_wdata", bus_wdata, 0);
    chk("ar_bus_we", bus_we, 0);
    chk("ar_resp_err", resp_err, 0);
    chk("ar_resp_rdata", resp_rdata, 0);
    n_resp = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_valid) n_resp++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    if (resp_valid) n_resp++;
    chk("ar_no_resp", n_resp, 0);
    issue(1'b0, 32'h0000_7000, 32'h0);
    tick();
    req_valid = 1'b0;
    bus_rdy = 1'b1; bus_rdata = 32'h0BAD_CAFE;
    tick();
    bus_rdy = 1'b0;
    chk("ar_post_resp_valid", resp_valid, 1);
    chk("ar_post_resp_rdata", resp_rdata, 32'h0BAD_CAFE);
    tick();

    // Back-to-back with slave always ready
    issue(1'b0, 32'h0000_8000, 32'h0);
    bus_rdy = 1'b1; bus_rdata = 32'h7777_0000;
    n_resp = 0;
    for (int c = 0; c < 9; c++) begin
      ready_seq[c] = req_ready;
      if (resp_valid) n_resp++;
      tick();
    end
    req_valid = 1'b0; bus_rdy = 1'b0;
    chk("b2b_ready_pattern", ready_seq, 9'b001_001_001);
    chk("b2b_resp_count", n_resp, 3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_master_if.md
BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width (matches `DATA_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum BUSY cycles before error (legal range 2..255).
REQ-004 SHALL have ports, one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline access request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  access address.
- req_wdata  in  DATA_WIDTH  write data.
- req_ready  out  1  request accepted this cycle.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- stall  out  1  pipeline hold.
- bus_req  out  1  address strobe to bus decoder.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_WIDTH  address to decoder/slaves.
- bus_wdata  out  DATA_WIDTH  write data to slaves.
- bus_rdy  in  1  ready from slave mux (master_rdy).
- bus_rdata  in  DATA_WIDTH  read data from slave mux (master_data).

Function
REQ-005 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-006 SHALL drive req_ready = 1 only in IDLE.
REQ-007 IDLE and req_valid = 1: SHALL register req_we/req_addr/req_wdata (wdata forced to 0 when req_we = 0), clear the timeout counter, go to BUSY.
REQ-008 IDLE and req_valid = 0: SHALL remain in IDLE.
REQ-009 SHALL assert bus_req = 1 in every BUSY cycle and 0 in all other states.
REQ-010 SHALL hold bus_we/bus_addr/bus_wdata stable from BUSY entry until return to IDLE, and drive them 0 in IDLE.
REQ-011 BUSY and bus_rdy = 1: SHALL register bus_rdata (reads) or 0 (writes) into resp_rdata, clear resp_err, go to DONE.
REQ-012 BUSY and bus_rdy = 0: SHALL increment the 8-bit timeout counter; when the counter equals TIMEOUT-1, SHALL set resp_err = 1, set resp_rdata = 0, go to DONE.
REQ-013 bus_rdy = 1 in the same cycle as timeout expiry: SHALL treat as success (bus_rdy wins).
REQ-014 SHALL assert resp_valid = 1 for exactly the one DONE cycle, then return to IDLE.
REQ-015 resp_rdata/resp_err SHALL hold their last values until the next completion.
REQ-016 SHALL ignore bus_rdy and bus_rdata outside BUSY.
REQ-017 SHALL ignore req_valid outside IDLE; the request is not queued.
REQ-018 SHALL assert stall = 1 whenever state is not IDLE.
REQ-019 Latency: accept at cycle 0, bus_req from cycle 1, bus_rdy high at cycle k (k >= 1) gives resp_valid at cycle k+1; minimum 2 cycles.
REQ-020 Back-to-back operation: a request presented in the IDLE cycle following DONE SHALL be accepted; throughput is at most one access per 3 cycles.

Reset
REQ-021 rst_n = 0 SHALL immediately force state IDLE, counter 0, bus_req/bus_we/resp_valid/resp_err/stall = 0, bus_addr/bus_wdata/resp_rdata = 0.
REQ-022 Reset asserted mid-BUSY or in DONE SHALL abort the access with no resp_valid pulse; operation resumes on the first rising edge after rst_n = 1.

Verification
REQ-023 Read with zero wait: req addr 0x1000, we = 0; bus_rdy = 1, bus_rdata = 0xDEADBEEF in cycle 1 -> resp_valid at cycle 2, resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-024 Write with 3 wait cycles: we = 1, wdata 0x12345678; bus_rdy high in cycle 4 -> bus_wdata stable cycles 1-4, resp_valid at cycle 5, resp_rdata = 0.
REQ-025 Timeout: TIMEOUT = 16, bus_rdy held 0 -> bus_req high 16 cycles, resp_valid with resp_err = 1 at cycle 17; then bus_rdy = 1 at TIMEOUT-1 -> resp_err = 0.
REQ-026 Reset mid-access: rst_n low at BUSY cycle 2 -> all outputs 0 asynchronously, no resp_valid; new request after release completes normally.
REQ-027 Back-to-back: req_valid held high, bus_rdy always 1 -> req_ready pulses every 3 cycles, three accesses complete in 9 cycles.
